mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Multi-cycle, width-parametrised RV32I-style datapath: successor to the single-cycle datapath.
//  Sequences FETCH/EXEC/MEM/WB with an internal FSM and talks to instruction/data memories over
//  req/ack handshakes, so memories may stall arbitrarily. Sits between the decoder/controller
//  (combinational on instr) and the memory system. Halt and fault are reported, not $finish'd.
// PARAMETERS
//  XLEN      32     datapath, register, PC and memory-address width
//  RESET_PC  'h0    PC value loaded on reset (XLEN bits, must be 4-byte aligned)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  hlt          in   1      controller: current instr is a halt (sampled in EXEC)
//  memtoreg     in   1      WB source: 0 alu result register, 1 load data register
//  pcsrc        in   1      branch taken select (qualified by zero in controller)
//  jumpsrc      in   1      jump base: 0 pc, 1 rs1
//  jump         in   1      next pc = (base+imm) & ~1
//  alusrcA      in   2      [0]: srcA = pc, else rs1
//  alusrcB      in   2      0 rs2, 1 imm, 2 constant 4
//  alusrc_a_zero in  1      force rs1 index to x0
//  alucontrol   in   4      ALU op (consts.v encoding)
//  regwrite     in   1      write rd in WB
//  memread      in   1      instr is a load
//  memwrite     in   1      instr is a store
//  instr        out  32     latched instruction register, to controller
//  pc           out  XLEN   current instruction address
//  zero         out  1      ALU zero flag (valid in EXEC)
//  imem_req     out  1      fetch request; imem_addr = pc while high
//  imem_ack     in   1      fetch accept + data valid, same cycle
//  imem_rdata   in   32     instruction word, valid with imem_ack
//  dmem_req     out  1      data request
//  dmem_we      out  1      1 store, 0 load; stable while dmem_req
//  dmem_addr    out  XLEN   ALU result register
//  dmem_wdata   out  XLEN   rs2 value captured in EXEC
//  dmem_ack     in   1      data accept (+ rdata valid for loads)
//  dmem_rdata   in   XLEN   load data, valid with dmem_ack
//  retire       out  1      one-cycle pulse in WB per completed instruction
//  halted       out  1      sticky: FSM in HALT
//  fault        out  1      sticky: halted due to misaligned next pc
// BEHAVIOUR
//  Reset (async): state=FETCH, pc=RESET_PC, instr=0 (nop-equivalent decode), aluout_q=0,
//   rdata_q=0, all req/we/retire/halted/fault=0. Register file contents not reset.
//  FETCH: imem_req=1 until imem_ack; on ack latch instr<=imem_rdata, go EXEC. req drops the
//   cycle after ack; addr stable while req high.
//  EXEC (1 cycle): ALU on srcA/srcB; latch aluout_q, wdata_q=rs2; compute next_pc:
//   jump ? ((jumpsrc?rs1:pc)+imm)&~1 : pcsrc ? pc+imm : pc+4, all mod 2^XLEN (wrap, no trap).
//   hlt=1 -> HALT (halted=1, no retire, pc unchanged). next_pc[1:0]!=0 -> HALT, fault=1.
//   Otherwise memread|memwrite -> MEM, else WB. memread&memwrite both set -> treat as store.
//  MEM: dmem_req=1, dmem_we=memwrite until dmem_ack; load latches rdata_q; go WB.
//  WB (1 cycle): if regwrite write rd <= memtoreg?rdata_q:aluout_q (x0 writes ignored);
//   pc<=next_pc; retire=1; go FETCH.
//  HALT: absorbing until reset; no requests issued.
//  Latency: ALU op = 3 cycles + imem stall; load/store = 4 cycles + imem + dmem stall.
//  Control inputs sampled only in EXEC (and memread/memwrite/regwrite/memtoreg held valid
//   via stable instr through WB). Reset mid-request drops req immediately; memory must
//   tolerate abandoned requests. imem_ack/dmem_ack outside their request are ignored.
//  imm from imm_sel sign-extended to XLEN; rs1/rs2 reads are combinational from regfile.
// STRUCTURE
//  consts.v: ALU op codes, FSM state encoding (S_FETCH,S_EXEC,S_MEM,S_WB,S_HALT), srcB codes.
//  Sub-module mc_dp_fsm: state register, handshake/req outputs, retire/halted/fault.
//  Reuse regfile, alu, imm_sel, flopr, mux2, mux3, adder (parametrised to XLEN).
// TESTING
//  addi x1,x0,5 with imem_ack immediate -> retire at cycle 3, x1=5, pc 0->4.
//  imem_ack delayed 4 cycles -> imem_req held, imem_addr stable, retire cycle 7.
//  sw x1,8(x0) then lw x2,8(x0), dmem_ack after 2 cycles -> dmem_we 1 then 0, addr 8, x2=5.
//  beq taken imm=-8 at pc=0x10 -> next pc 0x08; jalr rs1=0x21,imm=0 -> pc 0x20, rd=pc+4.
//  jal to pc+2 -> halted=1, fault=1, no retire; hlt instr -> halted=1, fault=0, no requests.
//  reset asserted mid-dmem_req -> req low same cycle, pc=RESET_PC, state FETCH after release.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: FSM state encoding, ALU op codes,
// ALU source-B select codes, RV32I opcodes and the immediate generator.
package mc_datapath_pkg;

  typedef enum logic [2:0] {StFetch, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;

  localparam logic [1:0] SrcBRs2  = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBFour = 2'd2;

  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Immediate selected by opcode; everything not listed decodes as I-type.
  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    unique case (i[6:0])
      OpStore:        imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      OpBranch:       imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OpJal:          imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      OpLui, OpAuipc: imm_gen = {i[31:12], 12'b0};
      default:        imm_gen = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/mc_dp_fsm.sv
// Sequencer for mc_datapath: FETCH/EXEC/MEM/WB/HALT state register plus registered
// handshake and status outputs.
//  clk_i, reset_i        clock, async active-high reset
//  imem_ack_i/dmem_ack_i memory accepts; ignored unless the matching request is high
//  hlt_i, misalign_i     EXEC-time halt request and misaligned next-pc flag
//  mem_op_i, memwrite_i  instruction needs MEM; store (wins over load)
//  state_o               current state for datapath register enables
//  imem_req_o, dmem_req_o, dmem_we_o, retire_o, halted_o, fault_o  registered outputs
module mc_dp_fsm
  import mc_datapath_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   imem_ack_i,
  input  logic   dmem_ack_i,
  input  logic   hlt_i,
  input  logic   misalign_i,
  input  logic   mem_op_i,
  input  logic   memwrite_i,
  output state_e state_o,
  output logic   imem_req_o,
  output logic   dmem_req_o,
  output logic   dmem_we_o,
  output logic   retire_o,
  output logic   halted_o,
  output logic   fault_o
);

  state_e state_q, state_d;
  logic   imem_req_q, dmem_req_q, dmem_we_q, retire_q, halted_q, fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    unique case (state_q)
      StFetch: if (imem_req_q && imem_ack_i) state_d = StExec;
      StExec: begin
        if (hlt_i) begin
          state_d = StHalt;
        end else if (misalign_i) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else if (mem_op_i) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem:   if (dmem_req_q && dmem_ack_i) state_d = StWb;
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q and
  // drop asynchronously with reset. Right after reset imem_req is low for one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StFetch;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= (state_d == StFetch);
      dmem_req_q <= (state_d == StMem);
      dmem_we_q  <= (state_d == StMem) && memwrite_i;
      retire_q   <= (state_d == StWb);
      halted_q   <= (state_d == StHalt);
      fault_q    <= fault_d;
    end
  end

  assign state_o    = state_q;
  assign imem_req_o = imem_req_q;
  assign dmem_req_o = dmem_req_q;
  assign dmem_we_o  = dmem_we_q;
  assign retire_o   = retire_q;
  assign halted_o   = halted_q;
  assign fault_o    = fault_q;

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-style datapath. The external controller decodes `instr`
// combinationally; memories use req/ack handshakes and may stall arbitrarily.
//  Control in : hlt, memtoreg, pcsrc, jumpsrc, jump, alusrcA, alusrcB, alusrc_a_zero,
//               alucontrol, regwrite, memread, memwrite
//  Status out : instr, pc, zero, retire, halted, fault
//  imem       : imem_req (address = pc), imem_ack, imem_rdata
//  dmem       : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_ack, dmem_rdata
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hlt,
  input  logic            memtoreg,
  input  logic            pcsrc,
  input  logic            jumpsrc,
  input  logic            jump,
  input  logic [1:0]      alusrcA,
  input  logic [1:0]      alusrcB,
  input  logic            alusrc_a_zero,
  input  logic [3:0]      alucontrol,
  input  logic            regwrite,
  input  logic            memread,
  input  logic            memwrite,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            zero,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            halted,
  output logic            fault
);

  localparam int unsigned ShW = $clog2(XLEN);

  state_e          state;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d, aluout_q, aluout_d, wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d, npc_q, npc_d;
  logic [XLEN-1:0] rf_q [32];
  logic [4:0]      rs1_idx, rs2_idx, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, src_a, src_b, alu_y, next_pc, jump_base;
  logic            misalign, rf_we, unused_alusrc_a;

  assign unused_alusrc_a = alusrcA[1];

  assign rs1_idx = alusrc_a_zero ? 5'd0 : instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign rd      = instr_q[11:7];
  assign rs1_val = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
  assign imm     = XLEN'($signed(imm_gen(instr_q)));

  assign src_a = alusrcA[0] ? pc_q : rs1_val;
  always_comb begin
    unique case (alusrcB)
      SrcBRs2: src_b = rs2_val;
      SrcBImm: src_b = imm;
      default: src_b = XLEN'(4);
    endcase
  end

  always_comb begin
    case (alucontrol)
      AluSub:  alu_y = src_a - src_b;
      AluAnd:  alu_y = src_a & src_b;
      AluOr:   alu_y = src_a | src_b;
      AluXor:  alu_y = src_a ^ src_b;
      AluSlt:  alu_y = XLEN'($signed(src_a) < $signed(src_b));
      AluSltu: alu_y = XLEN'(src_a < src_b);
      AluSll:  alu_y = src_a << src_b[ShW-1:0];
      AluSrl:  alu_y = src_a >> src_b[ShW-1:0];
      AluSra:  alu_y = $unsigned($signed(src_a) >>> src_b[ShW-1:0]);
      default: alu_y = src_a + src_b;
    endcase
  end
  assign zero = (alu_y == '0);

  // All additions wrap modulo 2^XLEN; misalignment is caught, not trapped.
  assign jump_base = jumpsrc ? rs1_val : pc_q;
  assign next_pc   = jump  ? ((jump_base + imm) & {{(XLEN-1){1'b1}}, 1'b0}) :
                     pcsrc ? (pc_q + imm) : (pc_q + XLEN'(4));
  assign misalign  = |next_pc[1:0];

  mc_dp_fsm u_fsm (
    .clk_i      (clk),
    .reset_i    (reset),
    .imem_ack_i (imem_ack),
    .dmem_ack_i (dmem_ack),
    .hlt_i      (hlt),
    .misalign_i (misalign),
    .mem_op_i   (memread | memwrite),
    .memwrite_i (memwrite),
    .state_o    (state),
    .imem_req_o (imem_req),
    .dmem_req_o (dmem_req),
    .dmem_we_o  (dmem_we),
    .retire_o   (retire),
    .halted_o   (halted),
    .fault_o    (fault)
  );

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    aluout_d = aluout_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    npc_d    = npc_q;
    unique case (state)
      StFetch: if (imem_req && imem_ack) instr_d = imem_rdata;
      StExec: begin
        aluout_d = alu_y;
        wdata_d  = rs2_val;
        npc_d    = next_pc;
      end
      StMem:   if (dmem_req && dmem_ack && !dmem_we) rdata_d = dmem_rdata;
      StWb:    pc_d = npc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      pc_q     <= RESET_PC;
      aluout_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      npc_q    <= RESET_PC;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      aluout_q <= aluout_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      npc_q    <= npc_d;
    end
  end

  // Register file is deliberately not reset; x0 is never written and reads as zero.
  assign rf_we = (state == StWb) && regwrite && (rd != 5'd0);
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[rd] <= memtoreg ? rdata_q : aluout_q;
  end

  assign instr      = instr_q;
  assign pc         = pc_q;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: acts as controller and both memories, with
// scoreboards for fetch addresses, retiring pcs and data-memory transactions.
module tb_mc_datapath;
  import mc_datapath_pkg::*;

  localparam logic [31:0] Hlt = 32'h0000_0073;
  localparam logic [6:0]  OpImm = 7'b0010011, OpLd = 7'b0000011, OpJalr = 7'b1100111;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dtx_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        hlt, memtoreg, pcsrc, jumpsrc, jump, alusrc_a_zero, regwrite, memread, memwrite;
  logic [1:0]  alusrcA, alusrcB;
  logic [3:0]  alucontrol;
  logic [31:0] instr, pc, dmem_addr, dmem_wdata, imem_rdata, dmem_rdata;
  logic        zero, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted, fault;

  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  logic [31:0] exp_fetch [$];
  logic [31:0] exp_retire [$];
  dtx_t        exp_dmem [$];
  int          imem_delay, dmem_delay, icnt, dcnt;
  logic        stray;
  int          vectors = 0, miscompares = 0;

  mc_datapath #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .hlt(hlt), .memtoreg(memtoreg), .pcsrc(pcsrc),
    .jumpsrc(jumpsrc), .jump(jump), .alusrcA(alusrcA), .alusrcB(alusrcB),
    .alusrc_a_zero(alusrc_a_zero), .alucontrol(alucontrol), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .instr(instr), .pc(pc), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .retire(retire), .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int rd, logic [6:0] op, int f3);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  // Reference controller: combinational decode of the latched instruction.
  always_comb begin
    hlt = 1'b0; memtoreg = 1'b0; pcsrc = 1'b0; jumpsrc = 1'b0; jump = 1'b0;
    alusrcA = 2'd0; alusrcB = SrcBImm; alusrc_a_zero = 1'b0; alucontrol = AluAdd;
    regwrite = 1'b0; memread = 1'b0; memwrite = 1'b0;
    case (instr[6:0])
      OpImm:    regwrite = 1'b1;
      OpLd:     begin memread = 1'b1; regwrite = 1'b1; memtoreg = 1'b1; end
      OpStore:  memwrite = 1'b1;
      OpBranch: begin alusrcB = SrcBRs2; alucontrol = AluSub; pcsrc = zero; end
      OpJal:    begin jump = 1'b1; alusrcA = 2'd1; alusrcB = SrcBFour; regwrite = 1'b1; end
      OpJalr: begin
        jump = 1'b1; jumpsrc = 1'b1; alusrcA = 2'd1; alusrcB = SrcBFour; regwrite = 1'b1;
      end
      7'b1110011: hlt = 1'b1;
      default: ;
    endcase
  end

  // Memory responders and scoreboard monitor; acks are driven for the next rising edge.
  always @(negedge clk) begin
    if (retire) begin
      chk("retire_expected", 32'(exp_retire.size() != 0), 32'd1);
      if (exp_retire.size() != 0) chk("retire_pc", pc, exp_retire.pop_front());
    end
    if (reset) begin
      imem_ack = 1'b0; dmem_ack = 1'b0; icnt = 0; dcnt = 0;
    end else begin
      if (imem_req) begin
        chk("fetch_expected", 32'(exp_fetch.size() != 0), 32'd1);
        if (exp_fetch.size() != 0) chk("fetch_addr", pc, exp_fetch[0]);
        if (icnt == imem_delay) begin
          imem_ack = 1'b1; imem_rdata = imem[pc[5:2]]; icnt = 0;
          if (exp_fetch.size() != 0) void'(exp_fetch.pop_front());
        end else begin
          imem_ack = 1'b0; icnt++;
        end
      end else begin
        imem_ack = stray; imem_rdata = Hlt; icnt = 0;
      end
      if (dmem_req) begin
        if (dcnt == dmem_delay) begin
          dtx_t e;
          chk("dmem_expected", 32'(exp_dmem.size() != 0), 32'd1);
          if (exp_dmem.size() != 0) begin
            e = exp_dmem.pop_front();
            chk("dmem_we", 32'(dmem_we), 32'(e.we));
            chk("dmem_addr", dmem_addr, e.addr);
            if (e.we) chk("dmem_wdata", dmem_wdata, e.wdata);
          end
          if (dmem_we) dmem[dmem_addr[5:2]] = dmem_wdata;
          else dmem_rdata = dmem[dmem_addr[5:2]];
          dmem_ack = 1'b1; dcnt = 0;
        end else begin
          dmem_ack = 1'b0; dcnt++;
        end
      end else begin
        dmem_ack = stray; dmem_rdata = 32'hDEAD_BEEF; dcnt = 0;
      end
    end
  end

  task automatic measure(output int lat);
    int n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    lat = 1;
    while (!retire && lat < 60) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 300) begin @(negedge clk); n++; end
    chk("halted", 32'(halted), 32'd1);
  endtask

  task automatic quiet_and_drain();
    logic any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any |= imem_req | dmem_req | retire;
    end
    chk("halt_quiet", 32'(any), 32'd0);
    chk("fetch_left", exp_fetch.size(), 32'd0);
    chk("retire_left", exp_retire.size(), 32'd0);
    chk("dmem_left", exp_dmem.size(), 32'd0);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = Hlt;
  endtask

  initial begin
    int lat;
    int n;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0; stray = 1'b0;
    icnt = 0; dcnt = 0;
    for (int i = 0; i < 16; i++) dmem[i] = '0;

    // Phase A1: addi / sw / lw / halt, immediate fetch, dmem ack after 2 cycles.
    clear_imem();
    imem[0] = enc_i(5, 0, 1, OpImm, 0);
    imem[1] = enc_s(8, 1, 0);
    imem[2] = enc_i(8, 0, 2, OpLd, 2);
    imem_delay = 0; dmem_delay = 2;
    exp_fetch = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_retire = '{32'h0, 32'h4, 32'h8};
    exp_dmem.push_back('{1'b1, 32'h8, 32'h5});
    exp_dmem.push_back('{1'b0, 32'h8, 32'h0});
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_reqs", {28'h0, imem_req, dmem_req, dmem_we, retire}, 32'h0);
    chk("rst_status", {30'h0, halted, fault}, 32'h0);
    reset = 1'b0;
    measure(lat);
    chk("alu_latency", lat, 32'd3);
    wait_halt();
    chk("a1_fault", 32'(fault), 32'd0);
    chk("a1_pc", pc, 32'hC);
    chk("a1_x1", dut.rf_q[1], 32'd5);
    chk("a1_x2", dut.rf_q[2], 32'd5);
    quiet_and_drain();

    // Phase A2: fetch stalled 4 cycles.
    clear_imem();
    imem[0] = enc_i(7, 0, 1, OpImm, 0);
    imem_delay = 4;
    exp_fetch = '{32'h0, 32'h4};
    exp_retire = '{32'h0};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure(lat);
    chk("stall_latency", lat, 32'd7);
    wait_halt();
    chk("a2_x1", dut.rf_q[1], 32'd7);
    chk("a2_pc", pc, 32'h4);
    quiet_and_drain();

    // Phase B: jal, taken beq backwards, jalr with odd target, not-taken beq.
    clear_imem();
    imem[0] = enc_i(32'h21, 0, 3, OpImm, 0);
    imem[1] = enc_j(12, 5);
    imem[2] = enc_i(0, 3, 4, OpJalr, 0);
    imem[4] = enc_b(-8, 0, 0);
    imem[8] = enc_b(16, 0, 3);
    imem_delay = 1;
    exp_fetch = '{32'h0, 32'h4, 32'h10, 32'h8, 32'h20, 32'h24};
    exp_retire = '{32'h0, 32'h4, 32'h10, 32'h8, 32'h20};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_halt();
    chk("b_x4_link", dut.rf_q[4], 32'hC);
    chk("b_x5_link", dut.rf_q[5], 32'h8);
    chk("b_pc", pc, 32'h24);
    chk("b_fault", 32'(fault), 32'd0);
    quiet_and_drain();

    // Phase C: jal to pc+2 faults; stray acks outside requests must be ignored.
    clear_imem();
    imem[0] = enc_j(2, 6);
    imem_delay = 0; stray = 1'b1;
    exp_fetch = '{32'h0};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_halt();
    chk("c_fault", 32'(fault), 32'd1);
    chk("c_pc", pc, 32'h0);
    quiet_and_drain();
    stray = 1'b0;

    // Phase D: reset while a store is waiting on dmem.
    clear_imem();
    imem[0] = enc_i(9, 0, 1, OpImm, 0);
    imem[1] = enc_s(4, 1, 0);
    dmem_delay = 1000;
    exp_fetch = '{32'h0, 32'h4};
    exp_retire = '{32'h0};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!dmem_req && n < 50) begin @(negedge clk); n++; end
    chk("d_req_seen", 32'(dmem_req), 32'd1);
    chk("d_we", 32'(dmem_we), 32'd1);
    chk("d_addr", dmem_addr, 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("d_rst_dreq", {30'h0, dmem_req, dmem_we}, 32'h0);
    chk("d_rst_pc", pc, 32'h0);
    chk("d_rst_instr", instr, 32'h0);
    chk("d_fetch_left", exp_fetch.size(), 32'd0);
    chk("d_retire_left", exp_retire.size(), 32'd0);
    imem[0] = Hlt;
    exp_fetch = '{32'h0};
    @(negedge clk);
    reset = 1'b0;
    wait_halt();
    chk("d_fault", 32'(fault), 32'd0);
    chk("d_pc", pc, 32'h0);
    quiet_and_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
